// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between writeback requesters.
// Writes to x0 and squashed requests are acknowledged without consuming a write slot.
package core;
  localparam int XLEN = 32;
  localparam int RD_W = 5;

  typedef struct packed {
    logic            en;
    logic [RD_W-1:0] rd_num;
    logic [XLEN-1:0] rd_value;
  } rf_write_req_t;
endpackage

module rf_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = core::XLEN,
  parameter int RD_W    = core::RD_W,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][RD_W-1:0]      req_rd_num,
  input  logic [NUM_REQ-1:0][XLEN-1:0]      req_rd_value,
  input  logic [NUM_REQ-1:0]                req_squash,
  output logic [NUM_REQ-1:0]                req_ready,
  output core::rf_write_req_t               rf_write_req,
  output logic [PTR_W-1:0]                  rr_ptr_o
);

  core::rf_write_req_t rf_write_req_q, rf_write_req_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]  live_s;
  logic [NUM_REQ-1:0]  drop_s;
  logic                active_s;
  logic                grant_found_s;
  logic [PTR_W-1:0]    grant_idx_s;
  logic [PTR_W:0]      scan_sum_s;
  logic [PTR_W-1:0]    scan_idx_s;

  assign active_s = en && !rst;

  // Classify each valid request: squash wins over the x0 check.
  always_comb begin
    live_s = '0;
    drop_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (req_squash[i] || (req_rd_num[i] == '0))) begin
        drop_s[i] = 1'b1;
      end else if (req_valid[i]) begin
        live_s[i] = 1'b1;
      end else begin
        live_s[i] = 1'b0;
      end
    end
  end

  // Pick the first live requester at or after the priority pointer, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    scan_sum_s    = '0;
    scan_idx_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_sum_s >= (PTR_W+1)'(NUM_REQ)) begin
        scan_sum_s = scan_sum_s - (PTR_W+1)'(NUM_REQ);
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[PTR_W-1:0];
      if (!grant_found_s && live_s[scan_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = scan_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Ready: every drop completes at once, plus the single granted live request.
  always_comb begin
    req_ready = '0;
    if (active_s) begin
      req_ready = drop_s;
      if (grant_found_s) begin
        req_ready[grant_idx_s] = 1'b1;
      end else begin
        req_ready = drop_s;
      end
    end else begin
      req_ready = '0;
    end
  end

  // Next write request and pointer; payload holds when nothing is granted.
  always_comb begin
    rf_write_req_d    = rf_write_req_q;
    rf_write_req_d.en = 1'b0;
    rr_ptr_d          = rr_ptr_q;
    if (active_s && grant_found_s) begin
      rf_write_req_d.en       = 1'b1;
      rf_write_req_d.rd_num   = req_rd_num[grant_idx_s];
      rf_write_req_d.rd_value = req_rd_value[grant_idx_s];
      if (grant_idx_s == PTR_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_s + PTR_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers; reset discards any in-flight write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write_req_q <= '0;
      rr_ptr_q       <= '0;
    end else begin
      rf_write_req_q <= rf_write_req_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign rf_write_req = rf_write_req_q;
  assign rr_ptr_o     = rr_ptr_q;

endmodule
